// File: rtl/prefetch_buffer_if.sv
// Bus bundle for prefetch_buffer: cache-side line read, write-path invalidate,
// and physical-memory line read.
interface prefetch_buffer_if;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic         inv;
  logic [31:0]  inv_address;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_read, mem_address, inv, inv_address, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_read, pmem_address
  );

  modport master (
    output mem_read, mem_address, inv, inv_address, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_read, pmem_address
  );
endinterface

// File: rtl/prefetch_buffer.sv
// Single-line next-line prefetch buffer between a cache and physical memory.
// Hits are answered combinationally; misses pass pmem data straight through.
module prefetch_buffer #(
  parameter bit PREFETCH_EN = 1'b1
) (
  input logic              clk,
  input logic              rst,
  prefetch_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEMAND   = 2'd1,
    PREFETCH = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           valid_q, valid_d;
  logic           drop_q, drop_d;
  logic [26:0]    tag_q, tag_d;
  logic [26:0]    pf_tag_q, pf_tag_d;
  logic [255:0]   data_q, data_d;

  logic [26:0]    req_line;
  logic [26:0]    inv_line;
  logic           inv_hits_buf;
  logic           inv_hits_pf;
  logic           hit;
  logic [9:0]     unused_low_bits;

  assign req_line        = bus.mem_address[31:5];
  assign inv_line        = bus.inv_address[31:5];
  assign unused_low_bits = {bus.mem_address[4:0], bus.inv_address[4:0]};

  assign inv_hits_buf = bus.inv & valid_q & (tag_q == inv_line);
  assign inv_hits_pf  = bus.inv & (pf_tag_q == inv_line);
  // An invalidate of the buffered line turns a same-cycle hit into a miss.
  assign hit = (state_q == IDLE) & bus.mem_read & valid_q
             & (tag_q == req_line) & ~inv_hits_buf;

  // NOTE: every output and next-state value gets a default before the case
  // so no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    state_d          = state_q;
    valid_d          = valid_q;
    drop_d           = drop_q;
    tag_d            = tag_q;
    pf_tag_d         = pf_tag_q;
    data_d           = data_q;
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_address = '0;

    if (inv_hits_buf) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hit) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = data_q;
          valid_d       = 1'b0;
          pf_tag_d      = req_line + 27'd1;
          state_d       = PREFETCH_EN ? PREFETCH : IDLE;
        end else if (bus.mem_read) begin
          state_d = DEMAND;
        end
      end

      DEMAND: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {req_line, 5'b0};
        if (bus.pmem_resp) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = bus.pmem_rdata;
          pf_tag_d      = req_line + 27'd1;
          state_d       = PREFETCH_EN ? PREFETCH : IDLE;
        end
      end

      PREFETCH: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {pf_tag_q, 5'b0};
        if (inv_hits_pf) drop_d = 1'b1;
        // A line invalidated while in flight (or on the fill edge) lands invalid.
        if (bus.pmem_resp) begin
          data_d  = bus.pmem_rdata;
          tag_d   = pf_tag_q;
          valid_d = ~(drop_q | inv_hits_pf);
          drop_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (rst) begin
      bus.mem_resp     = 1'b0;
      bus.mem_rdata    = '0;
      bus.pmem_read    = 1'b0;
      bus.pmem_address = '0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
      tag_q    <= '0;
      pf_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
      tag_q    <= tag_d;
      pf_tag_q <= pf_tag_d;
    end
  end

  // NOTE: the line data is deliberately not reset; valid_q guards every use,
  // so clearing 256 bits of storage would buy nothing.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: tb/tb_prefetch_buffer.sv
// Randomized bench for prefetch_buffer, checked against a transaction-level
// model: memory is a pure function of line address, buffer is {valid, line}.
module tb_prefetch_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         d_mem_read;
  logic [31:0]  d_mem_address;
  logic         d_inv;
  logic [31:0]  d_inv_address;
  logic         d_pmem_resp;
  logic [255:0] d_pmem_rdata;

  prefetch_buffer_if bus_en ();
  prefetch_buffer_if bus_dis ();

  assign bus_en.mem_read     = d_mem_read;
  assign bus_en.mem_address  = d_mem_address;
  assign bus_en.inv          = d_inv;
  assign bus_en.inv_address  = d_inv_address;
  assign bus_en.pmem_resp    = d_pmem_resp;
  assign bus_en.pmem_rdata   = d_pmem_rdata;
  assign bus_dis.mem_read    = d_mem_read;
  assign bus_dis.mem_address = d_mem_address;
  assign bus_dis.inv         = d_inv;
  assign bus_dis.inv_address = d_inv_address;
  assign bus_dis.pmem_resp   = d_pmem_resp;
  assign bus_dis.pmem_rdata  = d_pmem_rdata;

  prefetch_buffer #(.PREFETCH_EN(1'b1)) u_dut_en  (.clk(clk), .rst(rst), .bus(bus_en.slave));
  prefetch_buffer #(.PREFETCH_EN(1'b0)) u_dut_dis (.clk(clk), .rst(rst), .bus(bus_dis.slave));

  // The instance under test is chosen by the prefetch mode of the current phase.
  logic pf_en;
  logic         o_mem_resp, o_pmem_read;
  logic [255:0] o_mem_rdata;
  logic [31:0]  o_pmem_address;
  assign o_mem_resp     = pf_en ? bus_en.mem_resp     : bus_dis.mem_resp;
  assign o_pmem_read    = pf_en ? bus_en.pmem_read    : bus_dis.pmem_read;
  assign o_mem_rdata    = pf_en ? bus_en.mem_rdata    : bus_dis.mem_rdata;
  assign o_pmem_address = pf_en ? bus_en.pmem_address : bus_dis.pmem_address;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [255:0] mem_line(input logic [26:0] line);
    return {8{line, 5'h15}} ^ {8{32'hC3A5_0F1E}};
  endfunction

  // Reference model: buffered line, and at most one line fetch in flight.
  logic        bv;
  logic [26:0] btag;
  logic        f_act, f_dem, f_drop;
  logic [26:0] f_line;

  task automatic one_cycle(input logic r, input logic mr, input logic [31:0] ma,
                           input logic iv, input logic [31:0] ia, input logic pr,
                           output logic resp_seen);
    logic [26:0]  ln, il;
    logic         e_resp, e_pread, hit;
    logic [255:0] e_rdata;
    logic [31:0]  e_paddr;
    @(negedge clk);
    rst           = r;
    d_mem_read    = mr;
    d_mem_address = ma;
    d_inv         = iv;
    d_inv_address = ia;
    d_pmem_resp   = pr;
    d_pmem_rdata  = f_act ? mem_line(f_line) : {8{$urandom()}};
    #1;
    ln = ma[31:5];
    il = ia[31:5];
    e_resp = 1'b0; e_pread = 1'b0; e_rdata = '0; e_paddr = '0; hit = 1'b0;
    if (!r) begin
      if (f_act) begin
        e_pread = 1'b1;
        e_paddr = {f_line, 5'b0};
        if (f_dem && pr) begin
          e_resp  = 1'b1;
          e_rdata = mem_line(f_line);
        end
      end else begin
        hit = mr && bv && (btag == ln) && !(iv && btag == il);
        if (hit) begin
          e_resp  = 1'b1;
          e_rdata = mem_line(btag);
        end
      end
    end
    check("mem_resp", o_mem_resp, e_resp);
    check("pmem_read", o_pmem_read, e_pread);
    if (r || e_pread) check("pmem_address", o_pmem_address, e_paddr);
    if (r || e_resp)  check("mem_rdata", o_mem_rdata, e_rdata);
    resp_seen = e_resp;

    if (r) begin
      f_act = 1'b0; f_drop = 1'b0; bv = 1'b0; btag = '0;
    end else begin
      if (iv && bv && btag == il) bv = 1'b0;
      if (!f_act) begin
        if (hit) begin
          bv = 1'b0;
          if (pf_en) begin f_act = 1'b1; f_dem = 1'b0; f_drop = 1'b0; f_line = ln + 27'd1; end
        end else if (mr) begin
          f_act = 1'b1; f_dem = 1'b1; f_line = ln;
        end
      end else if (f_dem) begin
        if (pr) begin
          f_act = 1'b0;
          if (pf_en) begin f_act = 1'b1; f_dem = 1'b0; f_drop = 1'b0; f_line = f_line + 27'd1; end
        end
      end else begin
        if (iv && il == f_line) f_drop = 1'b1;
        if (pr) begin
          bv = !f_drop; btag = f_line; f_act = 1'b0;
        end
      end
    end
  endtask

  // Idle miss, demand answered on its first cycle, then one cycle offering a fill.
  task automatic miss_read(input logic [31:0] a);
    logic s;
    one_cycle(1'b0, 1'b1, a, 1'b0, '0, 1'b0, s);
    one_cycle(1'b0, 1'b1, a, 1'b0, '0, 1'b1, s);
    one_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, s);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [26:0] l;
    case ($urandom_range(0, 5))
      0: l = 27'h80;
      1: l = 27'h81;
      2: l = 27'h82;
      3: l = 27'h83;
      4: l = 27'h7FF_FFFF;
      default: l = 27'h0;
    endcase
    return {l, 5'($urandom_range(0, 31))};
  endfunction

  task automatic random_run(input int cycles);
    logic        req_out, s;
    logic [31:0] req_addr;
    req_out  = 1'b0;
    req_addr = '0;
    for (int k = 0; k < cycles; k++) begin
      if (!req_out && $urandom_range(0, 2) != 0) begin
        req_out  = 1'b1;
        req_addr = pick_addr();
      end
      one_cycle($urandom_range(0, 99) == 0, req_out, req_out ? req_addr : 32'h0,
                $urandom_range(0, 5) == 0, pick_addr(), $urandom_range(0, 2) == 0, s);
      if (s) req_out = 1'b0;
    end
  endtask

  initial begin
    logic s;
    rst = 1'b1; d_mem_read = 1'b0; d_mem_address = '0; d_inv = 1'b0;
    d_inv_address = '0; d_pmem_resp = 1'b0; d_pmem_rdata = '0;
    bv = 1'b0; btag = '0; f_act = 1'b0; f_dem = 1'b0; f_drop = 1'b0; f_line = '0;
    pf_en = 1'b1;

    // Reset holds outputs low even with a request and a stray pmem_resp present.
    one_cycle(1'b1, 1'b1, 32'h1004, 1'b0, '0, 1'b1, s);
    one_cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, s);

    // Miss at 0x1004, then prefetch of 0x1020.
    one_cycle(1'b0, 1'b1, 32'h1004, 1'b0, '0, 1'b0, s);
    miss_read(32'h1004);
    // Hit at 0x1030 on the prefetched line, then prefetch 0x1040.
    one_cycle(1'b0, 1'b1, 32'h1030, 1'b0, '0, 1'b0, s);
    one_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, s);
    // Buffer 0x1020, invalidate via 0x103C, re-read 0x1020 misses.
    miss_read(32'h1000);
    one_cycle(1'b0, 1'b0, '0, 1'b1, 32'h103C, 1'b0, s);
    miss_read(32'h1020);
    // Invalidate 0x1020 while it is being prefetched; re-read must miss.
    one_cycle(1'b0, 1'b1, 32'h1000, 1'b0, '0, 1'b0, s);
    one_cycle(1'b0, 1'b1, 32'h1000, 1'b0, '0, 1'b1, s);
    one_cycle(1'b0, 1'b0, '0, 1'b1, 32'h1020, 1'b0, s);
    one_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, s);
    miss_read(32'h1020);
    // Invalidate landing on the same edge as the fill of 0x1060.
    one_cycle(1'b0, 1'b1, 32'h1040, 1'b0, '0, 1'b0, s);
    one_cycle(1'b0, 1'b1, 32'h1040, 1'b0, '0, 1'b1, s);
    one_cycle(1'b0, 1'b0, '0, 1'b1, 32'h1060, 1'b1, s);
    miss_read(32'h1060);
    // Top line wraps its prefetch to line 0.
    miss_read(32'hFFFF_FFE0);
    one_cycle(1'b0, 1'b1, 32'h0000_0008, 1'b0, '0, 1'b0, s);
    one_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, s);
    // Reset mid-prefetch, then a stray pmem_resp; buffer stays empty.
    one_cycle(1'b0, 1'b1, 32'h2000, 1'b0, '0, 1'b0, s);
    one_cycle(1'b0, 1'b1, 32'h2000, 1'b0, '0, 1'b1, s);
    one_cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, s);
    one_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, s);
    miss_read(32'h2020);

    random_run(3000);

    // Same traffic shape with prefetch disabled.
    pf_en = 1'b0;
    one_cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, s);
    one_cycle(1'b0, 1'b1, 32'h1004, 1'b0, '0, 1'b0, s);
    miss_read(32'h1004);
    miss_read(32'hFFFF_FFE0);
    random_run(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
